byte_word_loader: RTL and testbench
===================================

BYTE_WORD_LOADER -- requirements
Module: byte_word_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 32, meaning number of 32-bit words in the target memory.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning memory address width, with DEPTH = 2**ADDR_W.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port frame_start  input  1  restarts loading at address 0.
REQ-006 SHALL have port byte_valid  input  1  byte_data holds a byte offered by upstream.
REQ-007 SHALL have port byte_data  input  8  incoming byte, little-endian within each word.
REQ-008 SHALL have port byte_ready  output  1  a byte is accepted when byte_valid and byte_ready are both 1 on a rising edge.
REQ-009 SHALL have port mem_we  output  1  one-cycle memory write strobe.
REQ-010 SHALL have port mem_addr  output  ADDR_W  memory word address.
REQ-011 SHALL have port mem_wdata  output  32  assembled word.
REQ-012 SHALL have port done  output  1  all DEPTH words have been written.
REQ-013 SHALL have port overflow  output  1  sticky flag for a byte offered after done.

Function
REQ-014 SHALL implement FSM states COLLECT, COMMIT and FULL.
REQ-015 SHALL, in COLLECT, keep byte_ready=1, store each accepted byte at lane byte_idx (0..3) of the word register, and increment byte_idx.
REQ-016 SHALL place the first byte of a word in [7:0], the second in [15:8], the third in [23:16] and the fourth in [31:24].
REQ-017 SHALL enter COMMIT when the 4th byte (byte_idx=3) is accepted, then assert mem_we=1 for exactly one cycle, with mem_wdata equal to the full word and mem_addr equal to the current word address.
REQ-018 SHALL give a latency of one cycle from the edge accepting the 4th byte to mem_we high.
REQ-019 SHALL hold byte_ready=0 in COMMIT and FULL; upstream holds its byte until it is accepted, and no byte is dropped.
REQ-020 SHALL, on leaving COMMIT when the address is below DEPTH-1, increment the address, clear byte_idx and return to COLLECT.
REQ-021 SHALL, on leaving COMMIT when the address equals DEPTH-1, not wrap the address, enter FULL and set done=1.
REQ-022 SHALL, in FULL, set overflow=1 whenever byte_valid=1; overflow stays set and nothing further is written.
REQ-023 SHALL, on frame_start=1 in any state, on the next edge set address=0, byte_idx=0, done=0, overflow=0 and the state to COLLECT, discarding any partial word.
REQ-024 SHALL give frame_start priority: a byte_valid in the same cycle is not accepted, and byte_ready SHALL read 0 that cycle.
REQ-025 SHALL, when frame_start coincides with COMMIT, suppress that cycle's mem_we.
REQ-026 SHALL hold mem_wdata and mem_addr stable whenever mem_we=0.

Reset
REQ-027 SHALL, when rst_n=0 at a rising edge, set state=COLLECT, byte_idx=0, address=0, word register=0, mem_we=0, done=0 and overflow=0.
REQ-028 SHALL hold byte_ready=0 during any cycle with rst_n=0, and let it rise the cycle after release.
REQ-029 SHALL abort a reset asserted mid-word or mid-COMMIT with no write issued.

Structure
REQ-030 SHALL take the FSM state encoding, DEPTH/ADDR_W defaults and the word width of 32 from the shared project package/header, so that the serializer side uses the same constants.
REQ-031 SHALL place the byte lane assembler (byte_idx counter and word register) in sub-module byte_assembler; the FSM and address counter stay in the top module.

Verification
REQ-032 SHALL cover: reset, then bytes 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> mem_we=1 one cycle later with mem_addr=0 and mem_wdata=0x44332211.
REQ-033 SHALL cover: a stream of 128 bytes, value k at byte k -> 32 writes at addresses 0..31 with each byte_ready=0 COMMIT gap honoured; done=1 after the 32nd write; byte_ready=0 afterward.
REQ-034 SHALL cover: in FULL, byte_valid=1 with 0xAA -> overflow=1, no mem_we; then frame_start -> overflow=0, done=0, mem_addr=0.
REQ-035 SHALL cover: two bytes 0x01, 0x02, then frame_start together with byte_valid for 0x03, then 0x05, 0x06, 0x07, 0x08 -> single write with addr=0 and data=0x08070605.
REQ-036 SHALL cover: rst_n=0 in the cycle after the 4th byte (COMMIT pending) -> no mem_we, all outputs at reset values.
REQ-037 SHALL cover: byte_valid toggling randomly with 0-3 idle cycles between bytes over 8 words -> written data matches the byte order exactly.

Source files
------------

// File: rtl/byte_word_loader_pkg.sv
// Shared constants and FSM encoding for the byte-to-word loader and its serializer
// counterpart.
package byte_word_loader_pkg;
  localparam int WORD_W     = 32;
  localparam int BYTE_W     = 8;
  localparam int DEPTH_DEF  = 32;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    COMMIT  = 2'd1,
    FULL    = 2'd2
  } load_state_e;
endpackage

// File: rtl/byte_word_loader_byte_assembler.sv
// Byte lane assembler: places accepted bytes little-endian into a word register
// and flags when the next accepted byte completes the word.
module byte_assembler
  import byte_word_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              accept_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic              last_o,
  output logic [WORD_W-1:0] word_o
);
  logic [1:0]        idx_q, idx_d;
  logic [WORD_W-1:0] word_q, word_d;

  // word_d already carries the incoming byte so the top can commit it on the same edge
  always_comb begin
    word_d = word_q;
    word_d[{idx_q, 3'b000} +: BYTE_W] = byte_i;
    idx_d = idx_q + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q  <= 2'd0;
      word_q <= '0;
    end else if (clear_i) begin
      idx_q <= 2'd0;
    end else if (accept_i) begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

  assign last_o = (idx_q == 2'd3);
  assign word_o = word_d;
endmodule

// File: rtl/byte_word_loader.sv
// Collects a little-endian byte stream into 32-bit words and writes them to
// consecutive memory addresses until the memory is full.
module byte_word_loader
  import byte_word_loader_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              done,
  output logic              overflow
);
  load_state_e       state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic              we_q, done_q, ovf_q;
  logic              accept, last;
  logic [WORD_W-1:0] word_full;

  assign byte_ready = rst_n && !frame_start && (state_q == COLLECT);
  assign accept     = byte_valid && byte_ready;

  byte_assembler u_asm (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (frame_start),
    .accept_i (accept),
    .byte_i   (byte_data),
    .last_o   (last),
    .word_o   (word_full)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (frame_start) begin
      state_q <= COLLECT;
      addr_q  <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        COLLECT: if (accept && last) begin
          state_q <= COMMIT;
          wdata_q <= word_full;
          we_q    <= 1'b1;
        end
        COMMIT: if (addr_q == ADDR_W'(DEPTH - 1)) begin
          state_q <= FULL;
          done_q  <= 1'b1;
        end else begin
          state_q <= COLLECT;
          addr_q  <= addr_q + 1'b1;
        end
        FULL: if (byte_valid) ovf_q <= 1'b1;
        default: state_q <= COLLECT;
      endcase
    end
  end

  // A reset or restart landing on the COMMIT cycle must cancel the write immediately
  assign mem_we    = we_q && rst_n && !frame_start;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign done      = done_q;
  assign overflow  = ovf_q;
endmodule

// File: tb/tb_byte_word_loader.sv
// Directed bench for byte_word_loader: basic word, full frame, overflow, restart,
// reset/restart during COMMIT and a gapped random-data stream.
module tb_byte_word_loader;
  logic        clk = 1'b0;
  logic        rst_n, frame_start, byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready, mem_we, done, overflow;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata;

  int checks = 0;
  int errors = 0;
  logic [4:0]  addr_log[$];
  logic [31:0] data_log[$];
  logic [7:0]  rb[32];

  always #5 clk = ~clk;

  byte_word_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .byte_ready  (byte_ready),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .done        (done),
    .overflow    (overflow)
  );

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      addr_log.push_back(mem_addr);
      data_log.push_back(mem_wdata);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d);
    int n;
    byte_valid = 1'b1;
    byte_data  = d;
    n = 0;
    @(negedge clk);
    while (byte_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (byte_ready !== 1'b1) chk("ready_timeout", 32'(byte_ready), 32'd1);
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic clear_logs();
    addr_log.delete();
    data_log.delete();
  endtask

  initial begin
    int bad;
    logic [31:0] expw;
    rst_n = 1'b0; frame_start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;

    // Reset state
    repeat (2) tick();
    @(negedge clk);
    chk("rst_ready",    32'(byte_ready), 32'd0);
    chk("rst_we",       32'(mem_we),     32'd0);
    chk("rst_addr",     32'(mem_addr),   32'd0);
    chk("rst_wdata",    mem_wdata,       32'h0);
    chk("rst_done",     32'(done),       32'd0);
    chk("rst_overflow", 32'(overflow),   32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", 32'(byte_ready), 32'd1);
    tick();

    // Single word
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    @(negedge clk);
    chk("w1_we",    32'(mem_we),     32'd1);
    chk("w1_addr",  32'(mem_addr),   32'd0);
    chk("w1_data",  mem_wdata,       32'h44332211);
    chk("w1_ready", 32'(byte_ready), 32'd0);
    tick();
    @(negedge clk);
    chk("w1_we_off",  32'(mem_we),     32'd0);
    chk("w1_addr_nx", 32'(mem_addr),   32'd1);
    chk("w1_ready_r", 32'(byte_ready), 32'd1);

    // Full frame of 128 bytes
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    clear_logs();
    for (int k = 0; k < 128; k++) send_byte(8'(k));
    @(negedge clk);
    chk("fr_last_we",   32'(mem_we), 32'd1);
    chk("fr_last_addr", 32'(mem_addr), 32'd31);
    chk("fr_last_data", mem_wdata, 32'h7F7E7D7C);
    tick();
    @(negedge clk);
    chk("fr_done",  32'(done),       32'd1);
    chk("fr_ready", 32'(byte_ready), 32'd0);
    chk("fr_count", 32'(addr_log.size()), 32'd32);
    bad = 0;
    for (int i = 0; i < 32 && i < addr_log.size(); i++) begin
      expw = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
      if (addr_log[i] !== 5'(i) || data_log[i] !== expw) bad++;
    end
    chk("fr_contents_bad", 32'(bad), 32'd0);

    // Overflow in FULL, then restart
    tick();
    byte_valid = 1'b1; byte_data = 8'hAA;
    @(negedge clk);
    chk("ov_ready", 32'(byte_ready), 32'd0);
    tick();
    byte_valid = 1'b0;
    @(negedge clk);
    chk("ov_flag",  32'(overflow), 32'd1);
    chk("ov_we",    32'(mem_we),   32'd0);
    chk("ov_count", 32'(addr_log.size()), 32'd32);
    tick();
    @(negedge clk);
    chk("ov_sticky", 32'(overflow), 32'd1);
    frame_start = 1'b1;
    @(negedge clk);
    chk("fs_ready", 32'(byte_ready), 32'd0);
    tick();
    frame_start = 1'b0;
    @(negedge clk);
    chk("fs_overflow", 32'(overflow),   32'd0);
    chk("fs_done",     32'(done),       32'd0);
    chk("fs_addr",     32'(mem_addr),   32'd0);
    chk("fs_ready_r",  32'(byte_ready), 32'd1);
    tick();

    // Partial word discarded by frame_start; coincident byte not taken
    clear_logs();
    send_byte(8'h01); send_byte(8'h02);
    frame_start = 1'b1; byte_valid = 1'b1; byte_data = 8'h03;
    @(negedge clk);
    chk("pw_ready", 32'(byte_ready), 32'd0);
    tick();
    frame_start = 1'b0; byte_valid = 1'b0;
    send_byte(8'h05); send_byte(8'h06); send_byte(8'h07); send_byte(8'h08);
    @(negedge clk);
    chk("pw_we",   32'(mem_we),   32'd1);
    chk("pw_addr", 32'(mem_addr), 32'd0);
    chk("pw_data", mem_wdata,     32'h08070605);
    tick();
    chk("pw_count", 32'(addr_log.size()), 32'd1);

    // Reset while COMMIT is pending
    clear_logs();
    send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3); send_byte(8'hA4);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rc_we",    32'(mem_we),     32'd0);
    chk("rc_ready", 32'(byte_ready), 32'd0);
    tick();
    @(negedge clk);
    chk("rc_addr",     32'(mem_addr), 32'd0);
    chk("rc_wdata",    mem_wdata,     32'h0);
    chk("rc_done",     32'(done),     32'd0);
    chk("rc_overflow", 32'(overflow), 32'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rc_ready_r", 32'(byte_ready), 32'd1);
    chk("rc_count",   32'(addr_log.size()), 32'd0);
    tick();

    // frame_start during COMMIT suppresses the write
    send_byte(8'hB1); send_byte(8'hB2); send_byte(8'hB3); send_byte(8'hB4);
    frame_start = 1'b1;
    @(negedge clk);
    chk("fc_we", 32'(mem_we), 32'd0);
    tick();
    frame_start = 1'b0;
    @(negedge clk);
    chk("fc_addr",  32'(mem_addr), 32'd0);
    chk("fc_count", 32'(addr_log.size()), 32'd0);
    tick();

    // Gapped stream with random data, 8 words
    for (int k = 0; k < 32; k++) rb[k] = 8'($urandom);
    for (int k = 0; k < 32; k++) begin
      repeat ($urandom_range(0, 3)) tick();
      send_byte(rb[k]);
    end
    repeat (3) tick();
    chk("rs_count", 32'(addr_log.size()), 32'd8);
    bad = 0;
    for (int i = 0; i < 8 && i < addr_log.size(); i++) begin
      expw = {rb[4*i+3], rb[4*i+2], rb[4*i+1], rb[4*i]};
      if (addr_log[i] !== 5'(i) || data_log[i] !== expw) bad++;
    end
    chk("rs_contents_bad", 32'(bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
